life_grid_engine: RTL and testbench
===================================

// Module: life_grid_engine
// PURPOSE
//  Game-of-Life generation engine directly upstream of vga_top's pixel/colour stage.
//  Holds the current and next cell grids. Computes one generation (rule B3/S23, toroidal wrap) at one cell per clk.
//  Commits the new generation only during vertical blanking, so a displayed frame never mixes generations.
//  The VGA stage reads cells through a registered read port using cell coordinates.
// PARAMETERS
//  COLS      32          grid width in cells (640 px / 20 px cells); >=3
//  ROWS      24          grid height in cells (480 px / 20 px cells); >=3
//  TICK_DIV  50_000_000  clk cycles of IDLE between auto generations (1 s at 50 MHz); >=1
// PORTS
//  clk        in   1   system clock (50 MHz); all logic on rising edge
//  reset      in   1   synchronous, active-high reset
//  run        in   1   1 = auto-advance every TICK_DIV idle cycles; 0 = freeze tick counter
//  step       in   1   single-cycle pulse; starts one generation if state is IDLE, else ignored
//  vblank     in   1   level from VGA timing; 1 during vertical blanking
//  rd_col     in   $clog2(COLS)  read column (0 = left)
//  rd_row     in   $clog2(ROWS)  read row (0 = top)
//  rd_cell    out  1   cur[rd_row][rd_col], registered (latency 1); 0 if address out of range
//  busy       out  1   1 in states SCAN and WAIT_VB
//  gen_count  out  16  number of committed generations; wraps 65535 -> 0
// BEHAVIOUR
//  - Storage:
//    - cur and nxt are COLS*ROWS-bit registers, index = row*COLS + col.
//    - Only cur is ever visible on rd_cell.
//  - Reset (sync, any state, including mid-SCAN):
//    - state = IDLE; tick_cnt = 0; scan_idx = 0; nxt = 0; gen_count = 0; busy = 0; rd_cell = 0.
//    - cur = seed glider: cells (col,row) = (1,0), (2,1), (0,2), (1,2), (2,2) live; all others dead.
//  - FSM states: IDLE, SCAN, WAIT_VB.
//  - IDLE:
//    - If run=1: tick_cnt increments each cycle. At TICK_DIV-1: tick_cnt <= 0 and state <= SCAN.
//    - If run=0: tick_cnt holds its value.
//    - If step=1: state <= SCAN and tick_cnt <= 0. This takes priority; step and tick expiry in the same cycle start one generation only.
//    - Entering SCAN sets scan_idx <= 0.
//  - SCAN (exactly COLS*ROWS cycles):
//    - Each cycle: count the 8 neighbours of cell scan_idx in cur, with wrap-around.
//      - Left of col 0 is col COLS-1; above row 0 is row ROWS-1; and the symmetric cases.
//      - Neighbour count width is 4 bits; it does not include the cell itself.
//    - Write nxt[scan_idx] = (cnt==3) | (cur[scan_idx] & cnt==2).
//    - scan_idx increments. After index COLS*ROWS-1: state <= WAIT_VB and scan_idx <= 0.
//    - step and run are ignored; the tick counter does not run.
//  - WAIT_VB:
//    - First cycle with vblank=1: cur <= nxt; gen_count <= gen_count+1; state <= IDLE.
//    - Waits indefinitely while vblank=0.
//  - Latency: step in IDLE at cycle t gives busy=1 for cycles t+1 .. t+N+K, where N = COLS*ROWS.
//    - K >= 1 is the number of WAIT_VB cycles.
//    - The new cur is visible on rd_cell from the second cycle after the commit edge (registered read).
//  - rd_cell: registered every cycle from the rd_col/rd_row presented in the previous cycle, independent of FSM state.
//    - A commit and a read in the same cycle return the old cur value.
// TESTING
//  1. Reset, then read all cells -> exactly (1,0),(2,1),(0,2),(1,2),(2,2) read 1; gen_count=0; busy=0.
//  2. vblank=1, run=0, pulse step -> busy high exactly 769 cycles; gen_count=1.
//     Then live cells are (0,1),(2,1),(1,2),(2,2),(1,3).
//  3. Four steps with vblank=1 -> glider shifted (+1,+1): live cells (2,1),(3,2),(1,3),(2,3),(3,3); gen_count=4.
//  4. COLS=8, ROWS=8, 32 steps -> grid identical to seed (toroidal wrap); gen_count=32.
//  5. TICK_DIV=10, run=1, vblank=0 -> FSM holds in WAIT_VB, busy stays 1, cur unchanged.
//     Raise vblank for 1 cycle -> commit; gen_count=1.
//  6. Assert reset mid-SCAN (scan_idx=300) -> next cycle: IDLE, busy=0, gen_count=0, grid equals seed.
//     A step during SCAN is ignored: gen_count increments only once.

Source files
------------

// File: rtl/life_grid_engine.sv
// Game-of-Life engine (B3/S23, toroidal grid): scans one cell per clock into a shadow grid and
// commits it to the displayed grid only during vertical blanking.
module life_grid_engine #(
    parameter int unsigned COLS     = 32,
    parameter int unsigned ROWS     = 24,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    step,
    input  logic                    vblank,
    input  logic [$clog2(COLS)-1:0] rd_col,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic                    rd_cell,
    output logic                    busy,
    output logic [15:0]             gen_count
);

    localparam int unsigned N  = COLS * ROWS;
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StWaitVb} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [N-1:0]    cur_q, cur_d;
    logic [N-1:0]    nxt_q, nxt_d;
    logic [15:0]     gen_q, gen_d;
    logic            rd_q, rd_d;

    int unsigned     c, r, cl, cr, ru, rdn;
    logic [3:0]      cnt;
    logic [IW-1:0]   scan_idx;
    logic            cell_self;
    logic            new_cell;
    logic            scan_last;
    logic            rd_in_range;
    logic [IW-1:0]   rd_idx;

    function automatic logic [N-1:0] seed_grid();
        logic [N-1:0] g;
        g = '0;
        g[1]          = 1'b1;
        g[COLS + 2]   = 1'b1;
        g[2 * COLS]   = 1'b1;
        g[2*COLS + 1] = 1'b1;
        g[2*COLS + 2] = 1'b1;
        return g;
    endfunction

    function automatic logic cell_at(input logic [N-1:0] g, input int unsigned rr,
                                     input int unsigned cc);
        logic [IW-1:0] i;
        i = IW'(rr * COLS + cc);
        return g[i];
    endfunction

    // Neighbour coordinates with wrap-around at every edge.
    always_comb begin
        c   = 32'(col_q);
        r   = 32'(row_q);
        cl  = (c == 0) ? COLS - 1 : c - 1;
        cr  = (c == COLS - 1) ? 0 : c + 1;
        ru  = (r == 0) ? ROWS - 1 : r - 1;
        rdn = (r == ROWS - 1) ? 0 : r + 1;
        cnt = 4'(cell_at(cur_q, ru, cl))  + 4'(cell_at(cur_q, ru, c))  + 4'(cell_at(cur_q, ru, cr))
            + 4'(cell_at(cur_q, r, cl))   + 4'(cell_at(cur_q, r, cr))
            + 4'(cell_at(cur_q, rdn, cl)) + 4'(cell_at(cur_q, rdn, c)) + 4'(cell_at(cur_q, rdn, cr));
        scan_idx  = IW'(r * COLS + c);
        cell_self = cur_q[scan_idx];
        new_cell  = (cnt == 4'd3) | (cell_self & (cnt == 4'd2));
        scan_last = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        col_d   = col_q;
        row_d   = row_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        gen_d   = gen_q;
        case (state_q)
            StIdle: begin
                if (step) begin
                    state_d = StScan;
                    tick_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else if (run) begin
                    if (tick_q == TW'(TICK_DIV - 1)) begin
                        state_d = StScan;
                        tick_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            StScan: begin
                nxt_d[scan_idx] = new_cell;
                if (scan_last) begin
                    state_d = StWaitVb;
                    col_d   = '0;
                    row_d   = '0;
                end else if (col_q == CW'(COLS - 1)) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            StWaitVb: begin
                if (vblank) begin
                    cur_d   = nxt_q;
                    gen_d   = gen_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read port sees cur_q before any same-cycle commit.
    always_comb begin
        rd_in_range = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
        rd_idx      = IW'(32'(rd_row) * COLS + 32'(rd_col));
        rd_d        = rd_in_range & cur_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cur_q   <= seed_grid();
            nxt_q   <= '0;
            gen_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            gen_q   <= gen_d;
            rd_q    <= rd_d;
        end
    end

    assign rd_cell   = rd_q;
    assign busy      = (state_q != StIdle);
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: a 32x24 instance for timing/commit/reset behaviour and
// an 8x8 instance for full toroidal glider wrap.
module tb_life_grid_engine;

    logic        clk;
    logic        reset, run, step, vblank;
    logic [4:0]  rd_col, rd_row;
    logic        rd_cell, busy;
    logic [15:0] gen_count;

    logic        reset8, run8, step8, vblank8;
    logic [2:0]  rd_col8, rd_row8;
    logic        rd_cell8, busy8;
    logic [15:0] gen_count8;

    int total = 0;
    int bad   = 0;

    life_grid_engine #(.COLS(32), .ROWS(24), .TICK_DIV(10)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .vblank(vblank),
        .rd_col(rd_col), .rd_row(rd_row), .rd_cell(rd_cell), .busy(busy),
        .gen_count(gen_count)
    );

    life_grid_engine #(.COLS(8), .ROWS(8), .TICK_DIV(10)) dut8 (
        .clk(clk), .reset(reset8), .run(run8), .step(step8), .vblank(vblank8),
        .rd_col(rd_col8), .rd_row(rd_row8), .rd_cell(rd_cell8), .busy(busy8),
        .gen_count(gen_count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [767:0] grid5(input int cols, input int c0, input int r0,
                                           input int c1, input int r1, input int c2,
                                           input int r2, input int c3, input int r3,
                                           input int c4, input int r4);
        logic [767:0] g;
        g = '0;
        g = g | (768'(1) << (r0 * cols + c0));
        g = g | (768'(1) << (r1 * cols + c1));
        g = g | (768'(1) << (r2 * cols + c2));
        g = g | (768'(1) << (r3 * cols + c3));
        g = g | (768'(1) << (r4 * cols + c4));
        return g;
    endfunction

    task automatic read_grid(output logic [767:0] g);
        g = '0;
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 32; c++) begin
                rd_col = 5'(c);
                rd_row = 5'(r);
                @(posedge clk);
                #1;
                g = g | (768'(rd_cell) << (r * 32 + c));
            end
        end
    endtask

    task automatic read_grid8(output logic [767:0] g);
        g = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                rd_col8 = 3'(c);
                rd_row8 = 3'(r);
                @(posedge clk);
                #1;
                g = g | (768'(rd_cell8) << (r * 8 + c));
            end
        end
    endtask

    task automatic step_main(output int cycles);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        cycles = 0;
        while (busy && cycles < 5000) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        check("step_done", 768'(busy), 768'(0));
    endtask

    task automatic step_small();
        int cycles;
        step8 = 1'b1;
        @(posedge clk);
        #1;
        step8 = 1'b0;
        cycles = 0;
        while (busy8 && cycles < 1000) begin
            cycles++;
            @(posedge clk);
            #1;
        end
        if (busy8) check("step8_timeout", 768'(busy8), 768'(0));
    endtask

    logic [767:0] seed, gen1, gen4, seed8, g;
    int cyc, n;

    initial begin
        seed  = grid5(32, 1, 0, 2, 1, 0, 2, 1, 2, 2, 2);
        gen1  = grid5(32, 0, 1, 2, 1, 1, 2, 2, 2, 1, 3);
        gen4  = grid5(32, 2, 1, 3, 2, 1, 3, 2, 3, 3, 3);
        seed8 = grid5(8, 1, 0, 2, 1, 0, 2, 1, 2, 2, 2);

        reset = 1'b1; run = 1'b0; step = 1'b0; vblank = 1'b1; rd_col = '0; rd_row = '0;
        reset8 = 1'b1; run8 = 1'b0; step8 = 1'b0; vblank8 = 1'b1; rd_col8 = '0; rd_row8 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        reset8 = 1'b0;

        // Reset state and seed glider
        check("reset_busy", 768'(busy), 768'(0));
        check("reset_gen", 768'(gen_count), 768'(0));
        check("reset_rd_cell", 768'(rd_cell), 768'(0));
        read_grid(g);
        check("seed_grid", g, seed);

        // Out-of-range row reads as dead
        rd_col = 5'd1;
        rd_row = 5'd24;
        @(posedge clk);
        #1;
        check("rd_out_of_range", 768'(rd_cell), 768'(0));

        // One generation: busy length and result
        step_main(cyc);
        check("busy_cycles", 768'(cyc), 768'(769));
        check("gen_after_1", 768'(gen_count), 768'(1));
        read_grid(g);
        check("grid_gen1", g, gen1);

        // Four generations: glider shifted by (+1,+1)
        for (int i = 0; i < 3; i++) step_main(cyc);
        check("gen_after_4", 768'(gen_count), 768'(4));
        read_grid(g);
        check("grid_gen4", g, gen4);

        // 8x8: 32 generations wrap the glider back onto its seed
        for (int i = 0; i < 32; i++) step_small();
        check("gen8_after_32", 768'(gen_count8), 768'(32));
        read_grid8(g);
        check("grid8_wrap", g, seed8);

        // Auto tick with vblank low: waits in WAIT_VB until vblank
        reset = 1'b1; run = 1'b1; vblank = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        while (!busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("tick_latency", 768'(n), 768'(10));
        repeat (800) @(posedge clk);
        #1;
        check("waitvb_busy", 768'(busy), 768'(1));
        check("waitvb_gen", 768'(gen_count), 768'(0));
        read_grid(g);
        check("waitvb_grid", g, seed);
        check("waitvb_busy_after_read", 768'(busy), 768'(1));
        rd_col = 5'd0;
        rd_row = 5'd2;
        vblank = 1'b1;
        @(posedge clk);
        #1;
        vblank = 1'b0;
        run = 1'b0;
        check("commit_gen", 768'(gen_count), 768'(1));
        check("commit_busy", 768'(busy), 768'(0));
        check("commit_read_old", 768'(rd_cell), 768'(1));
        @(posedge clk);
        #1;
        check("commit_read_new", 768'(rd_cell), 768'(0));
        read_grid(g);
        check("tick_grid_gen1", g, gen1);

        // Step pulse during SCAN is ignored
        reset = 1'b1; vblank = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            step = (cyc == 100);
            @(posedge clk);
            #1;
        end
        step = 1'b0;
        check("ignored_step_cycles", 768'(cyc), 768'(769));
        repeat (20) @(posedge clk);
        #1;
        check("ignored_step_gen", 768'(gen_count), 768'(1));
        check("ignored_step_idle", 768'(busy), 768'(0));

        // Reset in the middle of SCAN
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("mid_scan_busy", 768'(busy), 768'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_busy", 768'(busy), 768'(0));
        check("midreset_gen", 768'(gen_count), 768'(0));
        check("midreset_rd_cell", 768'(rd_cell), 768'(0));
        read_grid(g);
        check("midreset_grid", g, seed);
        check("midreset_stays_idle", 768'(busy), 768'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
